spi_fl_sequencer: RTL and testbench
===================================

SPI_FL_SEQUENCER -- requirements
Module: spi_fl_sequencer

Interface
REQ-001 Parameter POLL_MAX, default 16'd65535: maximum status-poll transfers before a timeout error is reported.
REQ-002 Parameter CT_CMD, default 3'b000: commtype for a command-only frame (WREN).
REQ-003 Parameter CT_CMD_ADDR, default 3'b010: commtype for command+address frames (erase).
REQ-004 Parameter CT_CMD_ADDR_DATA, default 3'b110: commtype for command+address+data frames (read, program).
REQ-005 Parameter CT_CMD_DATA, default 3'b100: commtype for command+data frames (status read).
REQ-006 clk  input  1  system clock; all logic is on the rising edge.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 req_valid  input  1  host request strobe.
REQ-009 req_op  input  2  00 read, 01 page-program word, 10 sector erase, 11 read status.
REQ-010 req_addr  input  24  flash byte address.
REQ-011 req_wdata  input  32  program data.
REQ-012 req_ready  output  1  high when IDLE; a request is accepted on req_valid & req_ready.
REQ-013 rsp_valid  output  1  one-cycle completion pulse.
REQ-014 rsp_rdata  output  32  read word, or status byte zero-extended.
REQ-015 rsp_err  output  1  poll timeout; valid with rsp_valid.
REQ-016 m_data_in, m_address, m_command, m_commtype, m_ndata_bits, m_frame_struct, m_xipbit_en, m_dummy_cycles  outputs  32/24/8/3/7/10/2/4  spi_master_fl controller fields.
REQ-017 m_validflag  output  1  one-cycle start pulse to spi_master_fl.
REQ-018 m_data_out  input  32; m_validflag_out  input  1; m_tready  input  1  spi_master_fl returns.

Function
REQ-019 States: IDLE, WREN, WREN_WAIT, OP, OP_WAIT, POLL, POLL_WAIT, RESP.
REQ-020 IDLE: on accept, latch op/addr/wdata and clear rsp_rdata; go to WREN for program/erase, OP for read/status.
REQ-021 Issue states (WREN, OP, POLL): drive fields, wait for m_tready=1, pulse m_validflag exactly one cycle, move to the matching _WAIT state.
REQ-022 _WAIT states: ignore m_tready for 2 cycles after the pulse, then leave on the first cycle m_tready=1.
REQ-023 WREN frame: command 8'h06, commtype CT_CMD, ndata_bits 0, dummy 0.
REQ-024 Read: command 8'h03, CT_CMD_ADDR_DATA, address req_addr, ndata_bits 32, dummy 0.
REQ-025 Program: command 8'h02, CT_CMD_ADDR_DATA, data_in req_wdata, ndata_bits 32.
REQ-026 Erase: command 8'h20, CT_CMD_ADDR, ndata_bits 0.
REQ-027 Status and poll: command 8'h05, CT_CMD_DATA, ndata_bits 8.
REQ-028 m_frame_struct=10'h0 and m_xipbit_en=2'b00 always.
REQ-029 m_data_out is captured into rsp_rdata on any cycle m_validflag_out=1 during OP_WAIT (read/status) or POLL_WAIT; status uses bits [7:0], zero-extended.
REQ-030 After OP_WAIT: read/status go to RESP; program/erase go to POLL with poll counter cleared.
REQ-031 POLL_WAIT exit: bit0 (WIP)=0 goes to RESP with rsp_err=0.
REQ-032 POLL_WAIT exit: WIP=1 with counter+1 < POLL_MAX increments the counter and returns to POLL.
REQ-033 POLL_WAIT exit: WIP=1 otherwise goes to RESP with rsp_err=1.
REQ-034 RESP: rsp_valid=1 for one cycle, then IDLE; req_ready returns high the cycle after rsp_valid.
REQ-035 req_valid while not IDLE is ignored (not queued).
REQ-036 Field outputs hold their values between issue and the next issue state.

Reset
REQ-037 rst=1 at any clock edge forces IDLE next cycle and abandons any in-flight flash transfer.
REQ-038 Reset values: m_validflag=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, all m_ fields 0, poll counter 0, req_ready=1 from the first cycle after reset.

Verification
REQ-039 Read at req_addr=24'h5A5A11, mock m_data_out=32'hA0A0A0A3 -> one 8'h03 pulse, rsp_rdata=32'hA0A0A0A3, rsp_err=0.
REQ-040 Program req_wdata=32'hDF000000, mock WIP sequence 1,1,0 -> pulses 06, 02, 05, 05, 05 in order; rsp_valid once, rsp_err=0.
REQ-041 Erase with POLL_MAX=4 and WIP stuck at 1 -> exactly 4 polls, then rsp_valid with rsp_err=1.
REQ-042 m_tready held low for 10 cycles in IDLE->OP -> no m_validflag until tready=1; pulse width exactly 1 cycle.
REQ-043 rst asserted during POLL_WAIT -> next cycle IDLE, req_ready=1, no rsp_valid; a following status request returns the mocked byte.
REQ-044 Second req_valid during a busy read -> ignored, exactly one rsp_valid produced.

Source files
------------

// File: rtl/spi_fl_sequencer_if.sv
// spi_fl_sequencer_if: host request/response bus plus the spi_master_fl field/handshake bundle.
// slave modport is the sequencer's view; master modport is the environment (host + flash controller).
interface spi_fl_sequencer_if;
  logic        req_valid;
  logic [1:0]  req_op;
  logic [23:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] m_data_in;
  logic [23:0] m_address;
  logic [7:0]  m_command;
  logic [2:0]  m_commtype;
  logic [6:0]  m_ndata_bits;
  logic [9:0]  m_frame_struct;
  logic [1:0]  m_xipbit_en;
  logic [3:0]  m_dummy_cycles;
  logic        m_validflag;
  logic [31:0] m_data_out;
  logic        m_validflag_out;
  logic        m_tready;
  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, m_data_out, m_validflag_out, m_tready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, m_data_in, m_address, m_command, m_commtype,
           m_ndata_bits, m_frame_struct, m_xipbit_en, m_dummy_cycles, m_validflag
  );
  modport master (
    output req_valid, req_op, req_addr, req_wdata, m_data_out, m_validflag_out, m_tready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, m_data_in, m_address, m_command, m_commtype,
           m_ndata_bits, m_frame_struct, m_xipbit_en, m_dummy_cycles, m_validflag
  );
endinterface

// File: rtl/spi_fl_sequencer.sv
// spi_fl_sequencer: turns host read/program/erase/status requests into spi_master_fl frame sequences.
// Ports: clk, rst (sync, active-high), bus (spi_fl_sequencer_if.slave: host req/rsp + flash controller fields).
module spi_fl_sequencer #(
  parameter logic [15:0] POLL_MAX         = 16'd65535,
  parameter logic [2:0]  CT_CMD           = 3'b000,
  parameter logic [2:0]  CT_CMD_ADDR      = 3'b010,
  parameter logic [2:0]  CT_CMD_ADDR_DATA = 3'b110,
  parameter logic [2:0]  CT_CMD_DATA      = 3'b100
) (
  input logic clk,
  input logic rst,
  spi_fl_sequencer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, WREN, WREN_WAIT, OP, OP_WAIT, POLL, POLL_WAIT, RESP} state_t;
  typedef enum logic [1:0] {F_NONE, F_WREN, F_OP, F_POLL} frame_t;
  state_t state, state_n;
  frame_t frame_q, frame;
  logic [1:0] op, wait_cnt;
  logic [23:0] addr;
  logic [31:0] wdata, rdata;
  logic [15:0] poll_cnt;
  logic [7:0] status;
  logic err, wr_op, accept, issue, wait_done, capture, more, stat;
  // program and erase are the ops that need WREN first and WIP polling afterwards
  assign wr_op = ^op;
  assign accept = state == IDLE && bus.req_valid;
  assign issue = (state == WREN || state == OP || state == POLL) && bus.m_tready && !rst;
  // the controller's tready is stale for two cycles after a start pulse
  assign wait_done = wait_cnt == 2'd2 && bus.m_tready;
  assign capture = bus.m_validflag_out && ((state == OP_WAIT && !wr_op) || state == POLL_WAIT);
  // status byte may arrive on the same cycle the wait ends, so bypass the register
  assign status = bus.m_validflag_out ? bus.m_data_out[7:0] : rdata[7:0];
  assign more = {1'b0, poll_cnt} + 17'd1 < {1'b0, POLL_MAX};
  // fields follow the issue state, otherwise hold the last issued frame
  assign frame = state == WREN ? F_WREN : state == OP ? F_OP : state == POLL ? F_POLL : frame_q;
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      state_n = bus.req_valid ? (^bus.req_op ? WREN : OP) : IDLE;
      WREN:      state_n = bus.m_tready ? WREN_WAIT : WREN;
      WREN_WAIT: state_n = wait_done ? OP : WREN_WAIT;
      OP:        state_n = bus.m_tready ? OP_WAIT : OP;
      OP_WAIT:   state_n = wait_done ? (wr_op ? POLL : RESP) : OP_WAIT;
      POLL:      state_n = bus.m_tready ? POLL_WAIT : POLL;
      POLL_WAIT: state_n = !wait_done ? POLL_WAIT : (status[0] && more ? POLL : RESP);
      default:   state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_q <= F_NONE;
      op <= '0;
      addr <= '0;
      wdata <= '0;
      rdata <= '0;
      err <= 1'b0;
      poll_cnt <= '0;
      wait_cnt <= '0;
    end else begin
      frame_q <= frame;
      wait_cnt <= issue ? 2'd0 : wait_cnt + {1'b0, wait_cnt != 2'd2};
      if (accept) begin
        op <= bus.req_op;
        addr <= bus.req_addr;
        wdata <= bus.req_wdata;
        rdata <= '0;
        err <= 1'b0;
      end
      if (capture) rdata <= state == OP_WAIT && op == 2'b00 ? bus.m_data_out : {24'd0, bus.m_data_out[7:0]};
      if (state == OP_WAIT && wait_done) poll_cnt <= '0;
      if (state == POLL_WAIT && wait_done && status[0]) begin
        poll_cnt <= poll_cnt + 16'd1;
        err <= !more;
      end
    end
  end
  always_comb begin
    stat = frame == F_POLL || (frame == F_OP && op == 2'b11);
    bus.req_ready = state == IDLE;
    bus.rsp_valid = state == RESP;
    bus.rsp_rdata = rdata;
    bus.rsp_err = err;
    bus.m_validflag = issue;
    bus.m_command = frame == F_WREN ? 8'h06 : stat ? 8'h05 : frame != F_OP ? 8'h00 :
                    op == 2'b00 ? 8'h03 : op == 2'b01 ? 8'h02 : 8'h20;
    bus.m_commtype = frame == F_WREN ? CT_CMD : stat ? CT_CMD_DATA : frame != F_OP ? 3'b000 :
                     op == 2'b10 ? CT_CMD_ADDR : CT_CMD_ADDR_DATA;
    bus.m_address = frame == F_OP && !stat ? addr : 24'd0;
    bus.m_data_in = frame == F_OP && op == 2'b01 ? wdata : 32'd0;
    bus.m_ndata_bits = stat ? 7'd8 : frame == F_OP && !op[1] ? 7'd32 : 7'd0;
    bus.m_frame_struct = '0;
    bus.m_xipbit_en = '0;
    bus.m_dummy_cycles = '0;
  end
endmodule

// File: tb/tb_spi_fl_sequencer.sv
// tb_spi_fl_sequencer: randomized host requests against a mock flash controller and a transaction-level model.
module tb_spi_fl_sequencer;
  localparam logic [15:0] PMAX = 16'd4;
  localparam logic [2:0] CT_C = 3'b000, CT_CA = 3'b010, CT_CAD = 3'b110, CT_CD = 3'b100;
  typedef struct packed {
    logic [31:0] din;
    logic [23:0] addr;
    logic [7:0]  cmd;
    logic [2:0]  ct;
    logic [6:0]  nb;
  } frame_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  spi_fl_sequencer_if bus();
  spi_fl_sequencer #(.POLL_MAX(PMAX), .CT_CMD(CT_C), .CT_CMD_ADDR(CT_CA), .CT_CMD_ADDR_DATA(CT_CAD),
                     .CT_CMD_DATA(CT_CD)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  int tests = 0, fails = 0, rsp_cnt = 0;
  frame_t exp_frames[$];
  logic [32:0] exp_rsp[$];
  logic [31:0] status_q[$];
  logic [7:0] seen_cmds[$];
  logic [31:0] mock_rd = '0, last_rdata = '0;
  logic last_err = 1'b0;
  bit saw_pulse = 0, prev_vf = 0, prev_rsp = 0, hold_low = 0;
  logic [7:0] saw_cmd = '0;
  function automatic frame_t fr(input logic [31:0] d, input logic [23:0] a, input logic [7:0] c,
                                input logic [2:0] t, input logic [6:0] n);
    fr = '{d, a, c, t, n};
  endfunction
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    frame_t f;
    logic [32:0] e;
    saw_pulse = bus.m_validflag && !rst;
    saw_cmd = bus.m_command;
    if (!rst) begin
      if (bus.m_validflag) begin
        f = fr(bus.m_data_in, bus.m_address, bus.m_command, bus.m_commtype, bus.m_ndata_bits);
        seen_cmds.push_back(bus.m_command);
        check("tready_at_pulse", bus.m_tready, 1'b1);
        check("pulse_width", prev_vf, 1'b0);
        check("fixed_fields", {bus.m_frame_struct, bus.m_xipbit_en, bus.m_dummy_cycles}, 16'h0);
        check("frame_expected", exp_frames.size() != 0, 1'b1);
        if (exp_frames.size() != 0) check("frame_fields", f, exp_frames.pop_front());
      end
      if (bus.rsp_valid) begin
        rsp_cnt++;
        last_rdata = bus.rsp_rdata;
        last_err = bus.rsp_err;
        check("ready_in_resp", bus.req_ready, 1'b0);
        check("rsp_expected", exp_rsp.size() != 0, 1'b1);
        if (exp_rsp.size() != 0) begin
          e = exp_rsp.pop_front();
          check("rsp_rdata", bus.rsp_rdata, e[32:1]);
          check("rsp_err", bus.rsp_err, e[0]);
        end
      end
      if (prev_rsp) check("ready_after_resp", bus.req_ready, 1'b1);
    end
    prev_vf = bus.m_validflag && !rst;
    prev_rsp = bus.rsp_valid && !rst;
  end
  // mock spi_master_fl: after each start pulse, tready low for 0..4 cycles, one data beat no earlier than cycle 3
  initial begin
    int k, lat, vk;
    logic [31:0] pend;
    bit busy;
    busy = 0;
    k = 0;
    lat = 0;
    vk = 0;
    pend = '0;
    bus.m_tready = 1'b1;
    bus.m_validflag_out = 1'b0;
    bus.m_data_out = '0;
    forever begin
      tick();
      if (saw_pulse) begin
        busy = 1;
        k = 0;
        lat = $urandom_range(0, 4);
        vk = lat > 3 ? lat : 3;
        pend = saw_cmd == 8'h03 ? mock_rd : saw_cmd == 8'h05 ? (status_q.size() != 0 ? status_q.pop_front() : 32'h0) : $urandom;
      end
      if (busy) begin
        k++;
        bus.m_tready = k >= lat;
        bus.m_validflag_out = k == vk;
        bus.m_data_out = k == vk ? pend : $urandom;
        busy = k < vk;
      end else begin
        bus.m_validflag_out = 1'b0;
        bus.m_data_out = $urandom;
        bus.m_tready = !hold_low && $urandom_range(0, 3) != 0;
      end
    end
  end
  // model: expected frame list and response computed per request; nbusy = polls that report WIP=1 first
  task automatic do_req(input logic [1:0] op, input logic [23:0] a, input logic [31:0] wd,
                        input logic [31:0] rw, input int nbusy, input bit spur);
    logic [31:0] w, rd;
    logic err;
    int n0, t;
    rd = '0;
    err = 1'b0;
    mock_rd = rw;
    if (op == 2'b00) begin
      exp_frames.push_back(fr(32'h0, a, 8'h03, CT_CAD, 7'd32));
      rd = rw;
    end else if (op == 2'b11) begin
      status_q.push_back(rw);
      exp_frames.push_back(fr(32'h0, 24'h0, 8'h05, CT_CD, 7'd8));
      rd = {24'h0, rw[7:0]};
    end else begin
      exp_frames.push_back(fr(32'h0, 24'h0, 8'h06, CT_C, 7'd0));
      if (op == 2'b01) exp_frames.push_back(fr(wd, a, 8'h02, CT_CAD, 7'd32));
      else exp_frames.push_back(fr(32'h0, a, 8'h20, CT_CA, 7'd0));
      err = 1'b1;
      for (int k = 1; k <= int'(PMAX); k++) begin
        w = $urandom;
        w[0] = k <= nbusy;
        status_q.push_back(w);
        exp_frames.push_back(fr(32'h0, 24'h0, 8'h05, CT_CD, 7'd8));
        rd = {24'h0, w[7:0]};
        if (!w[0]) begin
          err = 1'b0;
          break;
        end
      end
    end
    exp_rsp.push_back({rd, err});
    t = 0;
    while (!bus.req_ready && t < 100) begin
      tick();
      t++;
    end
    check("req_ready_wait", bus.req_ready, 1'b1);
    bus.req_valid = 1'b1;
    bus.req_op = op;
    bus.req_addr = a;
    bus.req_wdata = wd;
    n0 = rsp_cnt;
    tick();
    bus.req_valid = 1'b0;
    if (spur) begin
      bus.req_valid = 1'b1;
      bus.req_op = 2'($urandom);
      bus.req_addr = 24'($urandom);
      tick();
      tick();
      bus.req_valid = 1'b0;
    end
    t = 0;
    while (rsp_cnt == n0 && t < 400) begin
      tick();
      t++;
    end
    check("rsp_timeout", rsp_cnt != n0, 1'b1);
    tick();
    tick();
    check("rsp_once", rsp_cnt - n0, 1);
    check("frames_drained", exp_frames.size(), 0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end
  initial begin
    int n0, t;
    bus.req_valid = 1'b0;
    bus.req_op = '0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    repeat (3) tick();
    check("rst_req_ready", bus.req_ready, 1'b1);
    check("rst_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}, 34'h0);
    check("rst_fields", {bus.m_validflag, bus.m_data_in, bus.m_address, bus.m_command, bus.m_commtype,
                         bus.m_ndata_bits, bus.m_frame_struct, bus.m_xipbit_en, bus.m_dummy_cycles}, 91'h0);
    rst = 1'b0;
    tick();
    check("ready_after_reset", bus.req_ready, 1'b1);
    n0 = seen_cmds.size();
    do_req(2'b00, 24'h5A5A11, 32'h0, 32'hA0A0A0A3, 0, 0);
    check("read_pulses", seen_cmds.size() - n0, 1);
    check("read_cmd", seen_cmds[n0], 8'h03);
    check("read_rdata", last_rdata, 32'hA0A0A0A3);
    check("read_err", last_err, 1'b0);
    n0 = seen_cmds.size();
    do_req(2'b01, 24'h001000, 32'hDF000000, 32'h0, 2, 0);
    check("prog_pulses", seen_cmds.size() - n0, 5);
    check("prog_cmd0", seen_cmds[n0], 8'h06);
    check("prog_cmd1", seen_cmds[n0 + 1], 8'h02);
    for (int i = 2; i < 5; i++) check("prog_poll_cmd", seen_cmds[n0 + i], 8'h05);
    check("prog_err", last_err, 1'b0);
    n0 = seen_cmds.size();
    do_req(2'b10, 24'h020000, 32'h0, 32'h0, 100, 0);
    check("erase_pulses", seen_cmds.size() - n0, 6);
    check("erase_cmd1", seen_cmds[n0 + 1], 8'h20);
    check("erase_err", last_err, 1'b1);
    hold_low = 1;
    repeat (3) tick();
    n0 = seen_cmds.size();
    fork
      do_req(2'b11, 24'h0, 32'h0, 32'h1234_5602, 0, 0);
      begin
        repeat (10) tick();
        check("no_pulse_tready_low", seen_cmds.size() - n0, 0);
        hold_low = 0;
      end
    join
    check("status_rdata", last_rdata, 32'h0000_0002);
    n0 = seen_cmds.size();
    exp_frames.push_back(fr(32'h0, 24'h0, 8'h06, CT_C, 7'd0));
    exp_frames.push_back(fr(32'h5555_AAAA, 24'h00ABCD, 8'h02, CT_CAD, 7'd32));
    exp_frames.push_back(fr(32'h0, 24'h0, 8'h05, CT_CD, 7'd8));
    status_q.push_back(32'h0000_0003);
    bus.req_valid = 1'b1;
    bus.req_op = 2'b01;
    bus.req_addr = 24'h00ABCD;
    bus.req_wdata = 32'h5555_AAAA;
    tick();
    bus.req_valid = 1'b0;
    t = 0;
    while (seen_cmds.size() < n0 + 3 && t < 200) begin
      tick();
      t++;
    end
    check("reach_poll_wait", seen_cmds.size() - n0, 3);
    n0 = rsp_cnt;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_frames.delete();
    exp_rsp.delete();
    status_q.delete();
    check("midrst_ready", bus.req_ready, 1'b1);
    check("midrst_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}, 34'h0);
    check("midrst_fields", {bus.m_validflag, bus.m_command, bus.m_data_in}, 41'h0);
    repeat (8) tick();
    check("midrst_no_rsp", rsp_cnt - n0, 0);
    do_req(2'b11, 24'h0, 32'h0, 32'hFFFF_FF5C, 0, 0);
    check("post_rst_status", last_rdata, 32'h0000_005C);
    n0 = rsp_cnt;
    do_req(2'b00, 24'h123456, 32'h0, 32'hCAFE_F00D, 0, 1);
    repeat (12) tick();
    check("busy_req_ignored", rsp_cnt - n0, 1);
    for (int i = 0; i < 40; i++)
      do_req(2'($urandom), 24'($urandom), $urandom, $urandom, $urandom_range(0, 5), 1'($urandom_range(0, 1)));
    repeat (5) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
